// File: rtl/tick_countdown_timer.sv
// MM:SS BCD countdown timer advanced by rising edges of a slow square wave.
// The slow wave is synchronised and edge-detected into a one-cycle tick; it never clocks logic.
module tick_countdown_timer #(
  parameter logic [7:0] INIT_MIN = 8'h01,
  parameter logic [7:0] INIT_SEC = 8'h30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slow_clk,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       expired,
  output logic       done_pulse
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       done_q, done_d;
  logic       s1_q, s2_q, s3_q;
  logic       tick;
  logic       count_zero;
  logic       count_one;
  logic [15:0] count_dec;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // Digit-wise BCD decrement of {min_tens, min_ones, sec_tens, sec_ones}; caller ensures non-zero.
  function automatic logic [15:0] bcd_dec(input logic [15:0] cnt);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = cnt;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  // Two-flop synchroniser plus edge flop; tick marks a synchronised rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= slow_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick       = s2_q & ~s3_q;
  assign count_zero = (min_q == 8'h00) && (sec_q == 8'h00);
  assign count_one  = (min_q == 8'h00) && (sec_q == 8'h01);
  assign count_dec  = bcd_dec({min_q, sec_q});

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    done_d  = 1'b0;
    if (load) begin
      // A coincident tick is dropped because the load overwrites the count.
      min_d   = {clamp_digit(load_min[7:4], 4'd9), clamp_digit(load_min[3:0], 4'd9)};
      sec_d   = {clamp_digit(load_sec[7:4], 4'd5), clamp_digit(load_sec[3:0], 4'd9)};
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !count_zero) begin
            state_d = StRun;
          end
        end
        StRun: begin
          // start outranks pause and tick; while already running it simply holds.
          if (start) begin
            state_d = StRun;
          end else if (pause) begin
            state_d = StPause;
          end else if (tick) begin
            if (count_one) begin
              min_d   = 8'h00;
              sec_d   = 8'h00;
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              {min_d, sec_d} = count_dec;
            end
          end
        end
        StPause: begin
          if (start) begin
            state_d = StRun;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      min_q   <= INIT_MIN;
      sec_q   <= INIT_SEC;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      done_q  <= done_d;
    end
  end

  assign min_bcd    = min_q;
  assign sec_bcd    = sec_q;
  assign done_pulse = done_q;
  assign running    = (state_q == StRun);
  assign expired    = (state_q == StDone);

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Bench for tick_countdown_timer: directed scenarios plus random traffic against a
// reference model that counts in whole seconds and schedules ticks from sampled rises.
module tb_tick_countdown_timer;

  logic       clk;
  logic       rst;
  logic       slow_clk;
  logic       load;
  logic       start;
  logic       pause;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       expired;
  logic       done_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int pulses_seen = 0;

  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MPause = 2;
  localparam int MDone  = 3;

  // Reference model state: total seconds remaining, mode, done pulse.
  int m_cnt;
  int m_st;
  bit m_pulse;
  int edge_idx;
  bit prev_samp;
  int tick_due[$];

  tick_countdown_timer #(
    .INIT_MIN(8'h01),
    .INIT_SEC(8'h30)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .slow_clk  (slow_clk),
    .load      (load),
    .start     (start),
    .pause     (pause),
    .load_min  (load_min),
    .load_sec  (load_sec),
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .running   (running),
    .expired   (expired),
    .done_pulse(done_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic int clamp_val(input logic [7:0] b, input int tens_max);
    int t;
    int o;
    t = int'(b[7:4]);
    o = int'(b[3:0]);
    if (t > tens_max) t = tens_max;
    if (o > 9) o = 9;
    return t * 10 + o;
  endfunction

  // Model: a rise sampled at edge k takes effect on the count at edge k+2.
  always @(posedge clk or negedge rst) begin
    int  c;
    int  s;
    bit  p;
    bit  tick;
    if (!rst) begin
      m_cnt     <= 90;
      m_st      <= MIdle;
      m_pulse   <= 1'b0;
      prev_samp = 1'b0;
      tick_due.delete();
    end else begin
      edge_idx++;
      tick = 1'b0;
      while (tick_due.size() > 0 && tick_due[0] < edge_idx) void'(tick_due.pop_front());
      if (tick_due.size() > 0 && tick_due[0] == edge_idx) begin
        tick = 1'b1;
        void'(tick_due.pop_front());
      end
      if (slow_clk && !prev_samp) tick_due.push_back(edge_idx + 2);
      prev_samp = slow_clk;
      c = m_cnt;
      s = m_st;
      p = 1'b0;
      if (load) begin
        c = clamp_val(load_min, 9) * 60 + clamp_val(load_sec, 5);
        s = MIdle;
      end else begin
        case (m_st)
          MIdle:   if (start && c != 0) s = MRun;
          MRun: begin
            if (start) s = MRun;
            else if (pause) s = MPause;
            else if (tick) begin
              c = c - 1;
              if (c == 0) begin
                s = MDone;
                p = 1'b1;
              end
            end
          end
          MPause:  if (start) s = MRun;
          default: s = MDone;
        endcase
      end
      m_cnt   <= c;
      m_st    <= s;
      m_pulse <= p;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("min", 32'(min_bcd), 32'(to_bcd(m_cnt / 60)));
      check("sec", 32'(sec_bcd), 32'(to_bcd(m_cnt % 60)));
      check("running", 32'(running), 32'(m_st == MRun));
      check("expired", 32'(expired), 32'(m_st == MDone));
      check("done_pulse", 32'(done_pulse), 32'(m_pulse));
      if (done_pulse) pulses_seen++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic slow_rise();
    slow_clk = 1'b1;
    step(4);
    slow_clk = 1'b0;
    step(4);
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    load     = 1'b1;
    load_min = m;
    load_sec = s;
    step(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    int p0;
    int gap;
    edge_idx = 0;
    rst      = 1'b0;
    slow_clk = 1'b0;
    load     = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    load_min = 8'h00;
    load_sec = 8'h00;
    #12;
    check("rst_min", 32'(min_bcd), 32'h01);
    check("rst_sec", 32'(sec_bcd), 32'h30);
    check("rst_run", 32'(running), 32'h0);
    check("rst_exp", 32'(expired), 32'h0);
    step(2);
    rst = 1'b1;
    step(1);

    // Idle ignores ticks.
    repeat (5) slow_rise();
    check("idle_min", 32'(min_bcd), 32'h01);
    check("idle_sec", 32'(sec_bcd), 32'h30);

    // 00:12 down to expiry.
    do_load(8'h00, 8'h12);
    do_start();
    p0 = pulses_seen;
    for (int i = 1; i <= 12; i++) begin
      slow_rise();
      check("cd_sec", 32'(sec_bcd), 32'(to_bcd(12 - i)));
    end
    check("cd_pulses", 32'(pulses_seen - p0), 32'd1);
    check("cd_expired", 32'(expired), 32'h1);

    // Borrow chains.
    do_load(8'h01, 8'h00);
    do_start();
    slow_rise();
    check("borrow1", 32'({min_bcd, sec_bcd}), 32'h0059);
    do_load(8'h10, 8'h00);
    do_start();
    slow_rise();
    check("borrow2", 32'({min_bcd, sec_bcd}), 32'h0959);

    // Pause coincident with a tick drops the tick.
    do_load(8'h00, 8'h46);
    do_start();
    slow_rise();
    check("pz_pre", 32'(sec_bcd), 32'h45);
    slow_clk = 1'b1;
    step(2);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    step(1);
    slow_clk = 1'b0;
    step(4);
    repeat (3) slow_rise();
    check("pz_hold", 32'(sec_bcd), 32'h45);
    check("pz_run", 32'(running), 32'h0);
    do_start();
    slow_rise();
    check("pz_resume", 32'(sec_bcd), 32'h44);

    // Clamping and zero start.
    do_load(8'hA3, 8'h7C);
    check("clamp", 32'({min_bcd, sec_bcd}), 32'h9359);
    p0 = pulses_seen;
    do_load(8'h00, 8'h00);
    do_start();
    step(2);
    check("zero_run", 32'(running), 32'h0);
    check("zero_pulse", 32'(pulses_seen - p0), 32'd0);

    // Asynchronous reset mid-count.
    do_load(8'h00, 8'h21);
    do_start();
    slow_rise();
    check("mid_sec", 32'(sec_bcd), 32'h20);
    step(2);
    #2 rst = 1'b0;
    #1;
    check("ar_cnt", 32'({min_bcd, sec_bcd}), 32'h0130);
    check("ar_run", 32'(running), 32'h0);
    check("ar_pulse", 32'(done_pulse), 32'h0);
    step(1);
    rst = 1'b1;
    step(1);

    // DONE ignores start; load exits.
    do_load(8'h00, 8'h01);
    do_start();
    slow_rise();
    check("dn_exp", 32'(expired), 32'h1);
    do_start();
    step(2);
    check("dn_start", 32'(expired), 32'h1);
    do_load(8'h00, 8'h05);
    check("dn_load_exp", 32'(expired), 32'h0);
    check("dn_load_cnt", 32'({min_bcd, sec_bcd}), 32'h0005);

    // Random traffic.
    gap = 3;
    for (int i = 0; i < 4000; i++) begin
      gap--;
      if (gap <= 0) begin
        slow_clk = ~slow_clk;
        gap = int'($urandom_range(1, 6));
      end
      load     = ($urandom_range(0, 39) == 0);
      load_min = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
      load_sec = 8'($urandom);
      start    = ($urandom_range(0, 9) == 0) && (m_st != MRun);
      pause    = ($urandom_range(0, 29) == 0);
      step(1);
    end
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tick_countdown_timer.md
Name: tick_countdown_timer

Overview:
- Consumes the slow square wave from the clock divider.
- Synchronises that wave into the system clock domain and converts each rising edge into a one-cycle tick.
- Runs an MM:SS BCD countdown from a loadable value, with start, pause and load controls.
- Drives the BCD digits to the display stage and flags expiry. The slow wave is never used as a clock.

Parameters:
- INIT_MIN, 8'h01, BCD minutes loaded at reset.
- INIT_SEC, 8'h30, BCD seconds loaded at reset.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- slow_clk  input  1  divided square wave from the clock divider, asynchronous to clk sampling
- load  input  1  level; loads load_min/load_sec, state to IDLE
- start  input  1  level; IDLE/PAUSE -> RUN
- pause  input  1  level; RUN -> PAUSE
- load_min  input  8  BCD minutes {tens, ones}
- load_sec  input  8  BCD seconds {tens, ones}
- min_bcd  output  8  current minutes, BCD
- sec_bcd  output  8  current seconds, BCD
- running  output  1  high while state is RUN
- expired  output  1  high while state is DONE
- done_pulse  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; min_bcd=INIT_MIN; sec_bcd=INIT_SEC.
  - running=0, expired=0, done_pulse=0.
  - Synchroniser flops s1, s2 and edge flop s3 all cleared to 0.
  - Reset mid-count aborts immediately with no done_pulse.
- Tick generation:
  - s1<=slow_clk, s2<=s1, s3<=s2; tick = s2 & ~s3.
  - Exactly one tick per slow_clk rising edge; none on falling edges.
  - A slow_clk rise first sampled at clk edge N gives tick=1 in the cycle after edge N+1.
  - The count changes at edge N+2.
  - If slow_clk is already high at reset release, one tick is produced. This is harmless because the block is in IDLE.
- States: IDLE, RUN, PAUSE, DONE. Priority per cycle: load > start > pause > tick.
  - load (any state): the clamped load value is written; state=IDLE; a coincident tick is dropped.
  - IDLE: start with count != 00:00 -> RUN. start with count == 00:00 stays IDLE (no pulse). Ticks ignored.
  - RUN:
    - pause -> PAUSE; a coincident tick is dropped.
    - Otherwise, on a tick: if count == 00:01 the count becomes 00:00, state -> DONE and done_pulse=1 for that single cycle. Otherwise the count is decremented.
  - PAUSE: start -> RUN. Ticks ignored; the count is held.
  - DONE: count held at 00:00 and expired=1. start, pause and ticks are ignored; only load or reset exits.
  - The transition into RUN consumes no tick: a tick in the same cycle as start (from IDLE or PAUSE) is dropped.
- Decrement (BCD, all digit-wise, no binary conversion):
  - sec ones 0 -> 9 with a borrow from sec tens.
  - sec 00 -> 59 with a borrow from minutes.
  - min ones 0 -> 9 with a borrow from min tens.
  - Maximum count is 99:59.
- Load clamping:
  - Any digit > 9 becomes 9.
  - sec tens > 5 becomes 5.
  - Example: load_sec=8'h7C -> 8'h59.
- Outputs are registered; running/expired are decoded from the state register.

Test Plan:
- Reset release with defaults, no start, 5 slow_clk rises -> min_bcd=01, sec_bcd=30, running=0, expired=0.
- load 00:12, start, 12 slow_clk rises:
  - sec_bcd steps 11,10,09,...,01,00.
  - Each step lands 2 clk edges after the rise is sampled.
  - done_pulse=1 for exactly one cycle on the 12th step, then expired=1.
- load 01:00, start, 1 rise -> 00:59; load 10:00, start, 1 rise -> 09:59 (both borrow chains).
- RUN at 00:45, pause asserted on the same cycle as a tick -> count stays 00:45 through 3 further rises. start -> RUN; the next rise gives 00:44.
- load_min=8'hA3, load_sec=8'h7C -> min_bcd=93, sec_bcd=59. load 00:00 then start -> stays IDLE, no done_pulse.
- RUN at 00:20, rst pulled low between ticks -> outputs immediately 01:30/IDLE with no done_pulse. In DONE, start ignored; load 00:05 -> IDLE, expired=0.
